bf_stdout_uart: RTL and testbench
=================================

// Module: bf_stdout_uart
// PURPOSE
//   Consumer end of the BF core's stdout/stdout_en output. Captures each emitted byte into a
//   small FIFO and serialises it as 8N1 UART on uart_tx (LSB first).
//   Drives the core's enable (core_en) low while the FIFO is full. The core then freezes
//   instead of losing characters. Sits between the processor and the board TX pin.
// PARAMETERS
//   CLKS_PER_BIT  104  clk cycles per UART bit (12 MHz / 115200); legal >= 2
//   FIFO_DEPTH    8    byte slots in FIFO; power of two, >= 2
//   CNT_WIDTH     4    width of fifo_level; must hold FIFO_DEPTH
// PORTS
//   clk          in   1          system clock, all logic on posedge
//   reset        in   1          synchronous, active-high
//   stdout_data  in   8          byte from core stdout
//   stdout_en    in   1          byte valid from core; level may persist while core frozen
//   core_en      out  1          to core en; 0 = FIFO full, core must hold
//   uart_tx      out  1          serial line, idle high
//   tx_busy      out  1          1 while a frame (start..stop) is on the line
//   fifo_level   out  CNT_WIDTH  bytes currently queued (excludes the byte in the shifter)
// BEHAVIOUR
//   Reset values: uart_tx=1, tx_busy=0, fifo_level=0, core_en=1; FIFO pointers=0, state=IDLE.
//   Reset mid-frame truncates the frame: uart_tx=1 at the next edge; queued bytes are discarded.
//   core_en = (fifo_level != FIFO_DEPTH). It is combinational from registered level.
//   Push happens when stdout_en & core_en at a posedge. One push per asserted cycle.
//   The core clears stdout_en on its next enabled cycle, so each byte is pushed exactly once.
//     If the core is frozen with stdout_en=1, the byte is pushed on the first cycle that
//     core_en=1.
//   Push and pop in the same cycle: level unchanged. A push is never blocked by the pop in
//     that cycle, because the full check uses the pre-edge level.
//   Pointers wrap modulo FIFO_DEPTH. No overflow is possible; no underflow, because pop
//     requires level != 0.
//   TX FSM states: IDLE -> START -> DATA(8 bits, bit_idx 0..7) -> [PARITY] -> STOP -> IDLE.
//     - IDLE: if level != 0, pop into shift reg, go to START.
//       A pop and a push to an empty FIFO in the same cycle: no pop; the pop happens next cycle.
//     - START / DATA / PARITY / STOP: each bit is held for exactly CLKS_PER_BIT cycles.
//       A bit counter (width clog2(CLKS_PER_BIT)) counts 0..CLKS_PER_BIT-1, then advances.
//     - uart_tx is registered: 0 in START, shift[0] in DATA, 1 in STOP/IDLE.
//     - tx_busy=1 in all states except IDLE.
//   Latency: stdout_en sampled at edge E0 gives uart_tx falling after edge E2.
//     E0 = push; E1 = IDLE pop -> START.
//   Back-to-back frames have one IDLE cycle between the end of STOP and the next START.
//     Frame period is 10*CLKS_PER_BIT+1 cycles (11*CLKS_PER_BIT+1 with parity).
// CONFIGURATION
//   BF_UART_PARITY_EN defined:
//     - Adds a PARITY state between DATA and STOP, one bit time long.
//     - Parity bit = ^byte (even parity). Frame is 8E1.
//   BF_UART_PARITY_EN undefined: no PARITY state, frame is 8N1, no parity logic synthesised.
// STRUCTURE
//   Shared package bf_pkg:
//     - TX state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4).
//     - Constants UART_IDLE_LEVEL=1, DATA_BITS=8.
//   Sub-module bf_byte_fifo: synchronous FIFO with push/pop/level and wrap pointers; reset
//     clears it. The top module holds the TX FSM, bit timer, shifter and core_en.
// TESTING
//   1 Reset, then a single stdout_en pulse with 8'h41 -> uart_tx low 2 cycles later.
//       Bit sequence is 0,1,0,0,0,0,0,1,0,1; each bit exactly 104 cycles; tx_busy falls after
//       the stop bit.
//   2 Push 8 bytes 'A'..'H' in consecutive cycles -> fifo_level peaks at 7.
//       (The first byte is popped at E1.)
//       Serial output is 'A'..'H' in order, spaced 1041 cycles.
//   3 Fill to FIFO_DEPTH while stdout_en is held high with 8'h5A -> core_en=0, no extra push.
//       core_en rises after the next pop; 5A is pushed once on that cycle.
//       The decoded stream contains exactly one 5A.
//   4 Push and pop in the same cycle at level 3 -> level stays 3.
//       At level 0 with a push -> pop occurs the following cycle.
//   5 Assert reset during bit 3 of a frame -> uart_tx=1 and tx_busy=0 next edge.
//       fifo_level=0; no further frames are sent.
//   6 With BF_UART_PARITY_EN, send 8'h07 -> parity bit 1, frame 11 bits.
//       Without it, send 8'h07 -> frame 10 bits.

Source files
------------

// File: rtl/bf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bf_pkg                                                            |
// | Brief  : Shared TX state encodings and UART constants for bf_stdout_uart.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package bf_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   DATA_BITS       = 8;

    typedef logic [DATA_BITS-1:0] byte_t;

    function automatic logic even_parity(input byte_t b);
        return ^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bf_stdout_uart_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bf_stdout_uart_if                                                 |
// | Brief  : Core stdout handshake plus UART status bundle.                    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
interface bf_stdout_uart_if #(
    parameter int CNT_WIDTH = 4
);
    logic [7:0]           stdout_data;
    logic                 stdout_en;
    logic                 core_en;
    logic                 uart_tx;
    logic                 tx_busy;
    logic [CNT_WIDTH-1:0] fifo_level;

    modport master (
        output stdout_data, stdout_en,
        input  core_en, uart_tx, tx_busy, fifo_level
    );

    modport slave (
        input  stdout_data, stdout_en,
        output core_en, uart_tx, tx_busy, fifo_level
    );
endinterface
`default_nettype wire

// File: rtl/bf_byte_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bf_byte_fifo                                                      |
// | Brief  : Synchronous byte FIFO with wrapping pointers and level count.     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module bf_byte_fifo
    import bf_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = 4
) (
    input  wire                  clk,
    input  wire                  reset,
    input  wire                  push_i,
    input  wire                  pop_i,
    input  wire  [7:0]           wdata_i,
    output byte_t                rdata_o,
    output logic [CNT_WIDTH-1:0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);

    byte_t                mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_WIDTH-1:0] level_q;

    // The caller guarantees no push when full and no pop when empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   level_q <= level_q + CNT_WIDTH'(1);
                2'b01:   level_q <= level_q - CNT_WIDTH'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/bf_stdout_uart.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bf_stdout_uart                                                    |
// | Brief  : Buffers BF core stdout bytes and sends them as 8N1 UART, stalling |
// |          the core while the FIFO is full. BF_UART_PARITY_EN selects 8E1.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module bf_stdout_uart
    import bf_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_WIDTH    = 4
) (
    input  wire              clk,
    input  wire              reset,
    bf_stdout_uart_if.slave  bus
);

    localparam int                TIMER_W    = $clog2(CLKS_PER_BIT);
    localparam int                BIDX_W     = $clog2(DATA_BITS);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [BIDX_W-1:0]  BIDX_LAST  = BIDX_W'(DATA_BITS - 1);

    logic [2:0]           state_q,   state_d;
    logic [TIMER_W-1:0]   timer_q,   timer_d;
    logic [BIDX_W-1:0]    bit_idx_q, bit_idx_d;
    byte_t                shift_q,   shift_d;
    logic                 tx_q,      tx_d;

    logic                 core_en;
    logic                 push;
    logic                 pop;
    logic                 bit_done;
    byte_t                fifo_rdata;
    logic [CNT_WIDTH-1:0] level;

    // Full check uses the pre-edge level, so a same-cycle pop never unblocks a push.
    assign core_en  = (level != CNT_WIDTH'(FIFO_DEPTH));
    assign push     = bus.stdout_en & core_en;
    assign bit_done = (timer_q == TIMER_LAST);

    bf_byte_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (bus.stdout_data),
        .rdata_o (fifo_rdata),
        .level_o (level)
    );

`ifdef BF_UART_PARITY_EN
    logic parity_q, parity_d;
`endif

    always_comb begin
        state_d   = state_q;
        timer_d   = '0;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = UART_IDLE_LEVEL;
        pop       = 1'b0;
`ifdef BF_UART_PARITY_EN
        parity_d  = parity_q;
`endif
        if (state_q != ST_IDLE) begin
            timer_d = bit_done ? '0 : timer_q + TIMER_W'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (level != '0) begin
                    pop       = 1'b1;
                    shift_d   = fifo_rdata;
                    bit_idx_d = '0;
                    state_d   = ST_START;
`ifdef BF_UART_PARITY_EN
                    parity_d  = even_parity(fifo_rdata);
`endif
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (bit_done) state_d = ST_DATA;
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (bit_done) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + BIDX_W'(1);
                    if (bit_idx_q == BIDX_LAST) begin
`ifdef BF_UART_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef BF_UART_PARITY_EN
            ST_PARITY: begin
                tx_d = parity_q;
                if (bit_done) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                tx_d = UART_IDLE_LEVEL;
                if (bit_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The line register lags the state by one cycle, giving the two-edge push-to-start latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= UART_IDLE_LEVEL;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

`ifdef BF_UART_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) parity_q <= 1'b0;
        else       parity_q <= parity_d;
    end
`endif

    assign bus.core_en    = core_en;
    assign bus.uart_tx    = tx_q;
    assign bus.tx_busy    = (state_q != ST_IDLE);
    assign bus.fifo_level = level;

endmodule
`default_nettype wire

// File: tb/tb_bf_stdout_uart.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_bf_stdout_uart                                                 |
// | Brief  : Randomized bench for bf_stdout_uart against a queue/timing model. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_bf_stdout_uart;

    localparam int CPB   = 104;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
`ifdef BF_UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int SINCE_MAX = 1 << 20;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bf_stdout_uart_if #(.CNT_WIDTH(CW)) bus ();

    bf_stdout_uart #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: byte queue, cycles left in the current frame, edges since the last pop.
    logic [7:0]  mq [$];
    int          rem   = 0;
    int          since = SINCE_MAX;
    logic [10:0] frame = '1;
    logic        m_push = 1'b0;

    function automatic logic [10:0] mk_frame(input logic [7:0] b);
`ifdef BF_UART_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {2'b11, b, 1'b0};
`endif
    endfunction

    always @(posedge clk) begin
        int   lvl;
        logic cen;
        if (reset) begin
            mq.delete();
            rem    = 0;
            since  = SINCE_MAX;
            m_push = 1'b0;
        end else begin
            lvl    = mq.size();
            cen    = (lvl != DEPTH);
            m_push = bus.stdout_en && cen;
            if (rem == 0 && lvl != 0) begin
                frame = mk_frame(mq.pop_front());
                rem   = FB * CPB;
                since = 0;
            end else begin
                if (rem > 0) rem--;
                if (since < SINCE_MAX) since++;
            end
            if (m_push) mq.push_back(bus.stdout_data);
        end
    end

    function automatic logic exp_tx();
        if (since >= 1 && (since - 1) < FB * CPB) return frame[(since - 1) / CPB];
        return 1'b1;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout expected completion (t=%0t)", tag, $time);
    endtask

    task automatic step();
        logic [3:0] e_lvl;
        @(posedge clk);
        @(negedge clk);
        e_lvl = 4'(mq.size());
        check_val("outs", {25'd0, bus.core_en, bus.tx_busy, bus.uart_tx, bus.fifo_level},
                  {25'd0, (mq.size() != DEPTH), (rem != 0), exp_tx(), e_lvl});
    endtask

    task automatic send(input logic [7:0] b);
        int k = 0;
        bus.stdout_en   = 1'b1;
        bus.stdout_data = b;
        do begin
            step();
            k++;
        end while (!m_push && k < 20000);
        if (!m_push) timeout("send");
        bus.stdout_en = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((rem != 0 || mq.size() != 0) && k < 15000) begin
            step();
            k++;
        end
        if (k >= 15000) timeout("wait_idle");
        repeat (3) step();
    endtask

    task automatic wait_since(input int target, input string tag);
        int k = 0;
        while (since != target && k < 3000) begin
            step();
            k++;
        end
        if (since != target) timeout(tag);
    endtask

    initial begin
        logic pend;
        logic go;
        int   mode;

        reset           = 1'b1;
        bus.stdout_en   = 1'b0;
        bus.stdout_data = 8'h00;
        repeat (3) step();
        check_val("rst_tx",    bus.uart_tx,    1);
        check_val("rst_busy",  bus.tx_busy,    0);
        check_val("rst_level", bus.fifo_level, 0);
        check_val("rst_ce",    bus.core_en,    1);
        reset = 1'b0;
        step();

        // Single byte: latency and start-bit width.
        send(8'h41);
        check_val("t1_e0_level", bus.fifo_level, 1);
        check_val("t1_e0_busy",  bus.tx_busy,    0);
        step();
        check_val("t1_e1_tx",   bus.uart_tx, 1);
        check_val("t1_e1_busy", bus.tx_busy, 1);
        step();
        check_val("t1_e2_tx", bus.uart_tx, 0);
        repeat (CPB - 1) step();
        check_val("t1_start_end", bus.uart_tx, 0);
        step();
        check_val("t1_bit0", bus.uart_tx, 1);
        wait_idle();
        check_val("t1_idle_busy", bus.tx_busy, 0);

        // Eight back-to-back bytes.
        for (int i = 0; i < 8; i++) send(8'h41 + 8'(i));
        check_val("t2_peak", bus.fifo_level, 7);
        wait_idle();

        // Fill, then hold 5A while frozen.
        for (int i = 0; i < 9; i++) send(8'h61 + 8'(i));
        bus.stdout_en   = 1'b1;
        bus.stdout_data = 8'h5A;
        step();
        check_val("t3_full_ce",    bus.core_en,    0);
        check_val("t3_full_level", bus.fifo_level, DEPTH);
        send(8'h5A);
        check_val("t3_refill", bus.fifo_level, DEPTH);
        wait_idle();

        // Push and pop in the same cycle at level 3.
        for (int i = 0; i < 4; i++) send(8'h30 + 8'(i));
        begin
            int k = 0;
            while (rem != 0 && k < 2000) begin step(); k++; end
            if (rem != 0) timeout("t4_wait");
        end
        check_val("t4_pre_level", bus.fifo_level, 3);
        bus.stdout_en   = 1'b1;
        bus.stdout_data = 8'h34;
        step();
        bus.stdout_en = 1'b0;
        check_val("t4_pp_level", bus.fifo_level, 3);
        check_val("t4_pp_busy",  bus.tx_busy,    1);
        wait_idle();

        // Reset during data bit 3.
        for (int i = 0; i < 3; i++) send(8'hC3 + 8'(i));
        wait_since(1 + 4 * CPB + 30, "t5_wait");
        reset = 1'b1;
        step();
        check_val("t5_tx",    bus.uart_tx,    1);
        check_val("t5_busy",  bus.tx_busy,    0);
        check_val("t5_level", bus.fifo_level, 0);
        reset = 1'b0;
        repeat (2500) step();
        check_val("t5_quiet_tx",   bus.uart_tx, 1);
        check_val("t5_quiet_busy", bus.tx_busy, 0);

        // 8'h07: parity bit and frame length.
        send(8'h07);
        wait_since(1 + 9 * CPB + 50, "t6_wait9");
        check_val("t6_bit9", bus.uart_tx, 1);
        wait_since(1 + 10 * CPB + 50, "t6_wait10");
        check_val("t6_busy_bit10", bus.tx_busy, (FB == 11) ? 1 : 0);
        wait_idle();

        // Random traffic with varying burstiness and occasional reset.
        pend = 1'b0;
        mode = 0;
        for (int c = 0; c < 20000; c++) begin
            if (c % 2500 == 0) mode = $urandom_range(0, 2);
            if (!pend) begin
                case (mode)
                    0:       go = ($urandom_range(0, 1) == 0);
                    1:       go = ($urandom_range(0, 299) == 0);
                    default: go = 1'b1;
                endcase
                if (go) begin
                    bus.stdout_en   = 1'b1;
                    bus.stdout_data = 8'($urandom);
                    pend            = 1'b1;
                end else begin
                    bus.stdout_en = 1'b0;
                end
            end
            reset = ($urandom_range(0, 7999) == 0);
            step();
            if (pend && m_push) begin
                pend          = 1'b0;
                bus.stdout_en = 1'b0;
            end
        end
        bus.stdout_en = 1'b0;
        reset         = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
